// File: rtl/reset_seq_pkg.sv
// reset_seq_pkg: shared state encoding, reset-cause bit layout and counter sizing for reset_sequencer.
package reset_seq_pkg;
    typedef enum logic [1:0] {HOLD, STRETCH, RUN} state_t;
    localparam int CAUSE_W = 3;
    localparam int CAUSE_PLL = 0;
    localparam int CAUSE_BTN = 1;
    localparam int CAUSE_WDT = 2;
    localparam logic [CAUSE_W-1:0] CAUSE_POR = 3'b001;
    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction
endpackage

// File: rtl/reset_sequencer_debounce.sv
// reset_sequencer_debounce: synchroniser, stable-count debouncer and one-cycle release pulse for the GRESET button.
module reset_sequencer_debounce
    import reset_seq_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 65535
)(
    input  logic CLK,
    input  logic reset_in,
    input  logic raw,
    output logic level,
    output logic release_pulse
);
    localparam int CW = cnt_w(DEBOUNCE_CYCLES);
    logic [SYNC_STAGES-1:0] sync;
    logic [CW-1:0] cnt;
    logic in_s, flip;
    assign in_s = sync[SYNC_STAGES-1];
    assign flip = (in_s != level) && (cnt == CW'(DEBOUNCE_CYCLES - 1));
    always_ff @(posedge CLK or posedge reset_in) begin
        if (reset_in) begin
            sync          <= '0;
            cnt           <= '0;
            level         <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            sync          <= {sync[SYNC_STAGES-2:0], raw};
            cnt           <= (in_s == level || flip) ? '0 : cnt + 1'b1;
            level         <= level ^ flip;
            release_pulse <= flip && level;
        end
    end
endmodule

// File: rtl/reset_sequencer.sv
// reset_sequencer: merges PLL lock, debounced GRESET release and optional watchdog into one stretched sys_reset.
// The watchdog is built only when RESET_SEQ_WATCHDOG_EN is defined; otherwise wdt_kick is ignored.
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 65535,
    parameter int STRETCH_CYCLES  = 255,
    parameter int WDT_CYCLES      = 2**24
)(
    input  logic               CLK,
    input  logic               reset_in,
    input  logic               pll_locked,
    input  logic               btn_raw,
    input  logic               wdt_kick,
    output logic               sys_reset,
    output logic               ready,
    output logic [CAUSE_W-1:0] reset_cause
);
    localparam int STW = cnt_w(STRETCH_CYCLES);
    state_t state, state_nx;
    logic [STW-1:0] st_cnt, st_cnt_nx;
    logic [CAUSE_W-1:0] cause_nx, causes;
    logic [SYNC_STAGES-1:0] pll_sync;
    logic pll_ok, db_level, btn_release, wdt_expire;
    assign pll_ok = pll_sync[SYNC_STAGES-1];
    always_ff @(posedge CLK or posedge reset_in) begin
        if (reset_in) pll_sync <= '0;
        else pll_sync <= {pll_sync[SYNC_STAGES-2:0], pll_locked};
    end
    reset_sequencer_debounce #(
        .SYNC_STAGES(SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn (
        .CLK(CLK),
        .reset_in(reset_in),
        .raw(btn_raw),
        .level(db_level),
        .release_pulse(btn_release)
    );
`ifdef RESET_SEQ_WATCHDOG_EN
    localparam int WW = cnt_w(WDT_CYCLES);
    logic [WW-1:0] wdt_cnt;
    // A kick in the expiry cycle wins: it masks the expiry and restarts the count.
    assign wdt_expire = (state == RUN) && (wdt_cnt == WW'(WDT_CYCLES - 1)) && !wdt_kick;
    always_ff @(posedge CLK or posedge reset_in) begin
        if (reset_in) wdt_cnt <= '0;
        else wdt_cnt <= (state != RUN || wdt_kick || wdt_expire) ? '0 : wdt_cnt + 1'b1;
    end
`else
    logic wdt_unused;
    assign wdt_unused = wdt_kick;
    assign wdt_expire = 1'b0;
`endif
    always_comb begin
        causes            = '0;
        causes[CAUSE_PLL] = !pll_ok;
        causes[CAUSE_BTN] = btn_release;
        causes[CAUSE_WDT] = wdt_expire;
        state_nx          = state;
        st_cnt_nx         = '0;
        cause_nx          = reset_cause;
        unique case (state)
            HOLD:    state_nx = (pll_ok && !db_level) ? STRETCH : HOLD;
            STRETCH: begin
                if (!pll_ok || db_level) state_nx = HOLD;
                else if (st_cnt == STW'(STRETCH_CYCLES - 1)) state_nx = RUN;
                else st_cnt_nx = st_cnt + 1'b1;
            end
            RUN: begin
                if (|causes) begin
                    state_nx = HOLD;
                    cause_nx = causes;
                end
            end
            default: state_nx = HOLD;
        endcase
    end
    // Outputs are registered from the next state so sys_reset never glitches on state decode.
    always_ff @(posedge CLK or posedge reset_in) begin
        if (reset_in) begin
            state       <= HOLD;
            st_cnt      <= '0;
            reset_cause <= CAUSE_POR;
            sys_reset   <= 1'b1;
            ready       <= 1'b0;
        end else begin
            state       <= state_nx;
            st_cnt      <= st_cnt_nx;
            reset_cause <= cause_nx;
            sys_reset   <= state_nx != RUN;
            ready       <= state_nx == RUN;
        end
    end
endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: directed scoreboard bench; expected sys_reset edges are queued by the stimulus and checked by a monitor.
module tb_reset_sequencer;
    localparam int SS = 2;
    localparam int DB = 8;
    localparam int ST = 10;
    localparam int WD = 50;
    typedef struct {
        int         at;
        logic       lvl;
        logic [2:0] cause;
    } exp_t;
    logic CLK = 1'b0;
    logic reset_in = 1'b1;
    logic pll_locked = 1'b0;
    logic btn_raw = 1'b0;
    logic wdt_kick = 1'b0;
    logic sys_reset, ready;
    logic [2:0] reset_cause;
    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int c;
    int kick_cyc = -1;
    logic kick_en = 1'b1;
    logic prev_rst = 1'b1;
    exp_t q[$];

    reset_sequencer #(
        .SYNC_STAGES(SS),
        .DEBOUNCE_CYCLES(DB),
        .STRETCH_CYCLES(ST),
        .WDT_CYCLES(WD)
    ) dut (
        .CLK(CLK),
        .reset_in(reset_in),
        .pll_locked(pll_locked),
        .btn_raw(btn_raw),
        .wdt_kick(wdt_kick),
        .sys_reset(sys_reset),
        .ready(ready),
        .reset_cause(reset_cause)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            #2;
        end
    endtask

    function automatic void expect_edge(input int at, input logic lvl, input logic [2:0] cause);
        exp_t e;
        e.at = at;
        e.lvl = lvl;
        e.cause = cause;
        q.push_back(e);
    endfunction

    task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %03b required %03b at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Kicker owns wdt_kick: periodic kicks while enabled plus one directed kick at kick_cyc.
    initial forever begin
        @(posedge CLK);
        #2;
        wdt_kick = (kick_en && (cyc % 16 == 0)) || (cyc == kick_cyc);
    end

    always @(negedge CLK) begin
        exp_t e;
        if (sys_reset !== prev_rst) begin
            prev_rst <= sys_reset;
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL edge_unexpected: sys_reset=%0b cause=%03b at cycle %0d, no edge required", sys_reset, reset_cause, cyc);
            end else begin
                e = q.pop_front();
                if (cyc != e.at || sys_reset !== e.lvl || ready !== !e.lvl || reset_cause !== e.cause) begin
                    errors++;
                    $display("FAIL edge_at_%0d: got cycle %0d sys_reset=%0b ready=%0b cause=%03b, required cycle %0d sys_reset=%0b ready=%0b cause=%03b",
                             e.at, cyc, sys_reset, ready, reset_cause, e.at, e.lvl, !e.lvl, e.cause);
                end
            end
        end
    end

    initial begin
        tick(3);
        check("reset_sys_reset", 3'(sys_reset), 3'd1);
        check("reset_ready", 3'(ready), 3'd0);
        check("reset_cause", reset_cause, 3'b001);
        reset_in = 1'b0;
        tick(4);
        check("hold_without_lock", 3'(sys_reset), 3'd1);
        // Power-up: sys_reset falls SYNC_STAGES+11 edges after lock.
        c = cyc;
        pll_locked = 1'b1;
        expect_edge(c + SS + 11, 1'b0, 3'b001);
        tick(20);
        check("powerup_ready", 3'(ready), 3'd1);
        check("powerup_cause", reset_cause, 3'b001);
        // Bounce never settles long enough to change the debounced level.
        for (int i = 0; i < 40; i++) begin
            btn_raw = ((i / 3) % 2) == 1;
            tick(1);
        end
        btn_raw = 1'b0;
        tick(20);
        check("bounce_no_reset", 3'(sys_reset), 3'd0);
        // Press then release: reset on release, 11-cycle minimum width.
        btn_raw = 1'b1;
        tick(20);
        check("press_no_reset", 3'(sys_reset), 3'd0);
        c = cyc;
        btn_raw = 1'b0;
        expect_edge(c + DB + SS + 1, 1'b1, 3'b010);
        expect_edge(c + DB + SS + 1 + ST + 1, 1'b0, 3'b010);
        tick(40);
        // Lock loss in RUN, then lock loss at stretch count 5.
        c = cyc;
        pll_locked = 1'b0;
        expect_edge(c + SS + 1, 1'b1, 3'b001);
        tick(10);
        c = cyc;
        pll_locked = 1'b1;
        tick(SS + 1 + 5);
        pll_locked = 1'b0;
        tick(6);
        check("stretch_abort_hold", 3'(sys_reset), 3'd1);
        c = cyc;
        pll_locked = 1'b1;
        expect_edge(c + SS + 11, 1'b0, 3'b001);
        tick(20);
        // Lock loss and button release seen in the same RUN cycle.
        btn_raw = 1'b1;
        tick(20);
        c = cyc;
        btn_raw = 1'b0;
        tick(8);
        pll_locked = 1'b0;
        expect_edge(c + 11, 1'b1, 3'b011);
        tick(20);
        check("simul_hold", 3'(sys_reset), 3'd1);
        // Watchdog: expiry without kicks, then a kick in the expiry cycle.
        kick_en = 1'b0;
        c = cyc;
        pll_locked = 1'b1;
        expect_edge(c + 13, 1'b0, 3'b011);
`ifdef RESET_SEQ_WATCHDOG_EN
        expect_edge(c + 13 + WD, 1'b1, 3'b100);
        expect_edge(c + 13 + WD + ST + 1, 1'b0, 3'b100);
        kick_cyc = c + 13 + WD + ST + 1 + WD - 1;
        tick(130);
        kick_en = 1'b1;
        tick(70);
        check("wdt_kick_saves", 3'(sys_reset), 3'd0);
`else
        tick(100);
        check("no_wdt_run", 3'(sys_reset), 3'd0);
        check("no_wdt_cause", 3'(reset_cause[2]), 3'd0);
`endif
        // reset_in mid-RUN aborts at once; sequence restarts from power-on.
        c = cyc;
        reset_in = 1'b1;
        expect_edge(c, 1'b1, 3'b001);
        tick(2);
        reset_in = 1'b0;
        c = cyc;
        expect_edge(c + SS + 11, 1'b0, 3'b001);
        tick(20);
        check("final_ready", 3'(ready), 3'd1);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL edges_missing: got %0d pending edges required 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
